pixel_readout_ctrl: RTL

- Parametrised frame sequencer for the pixel sensor array: erase -> expose -> convert -> read.
- Drives array control strobes, the shared ADC ramp counter, and row/column-group selects.
- Packs selected pixel codes onto a DATA_W databus with valid/ready backpressure.
- Generalises the fixed single-size top: configurable rows, columns and ADC bits, programmable exposure, and a continuous-frame mode.

---
 rtl/pixel_readout_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pixel_readout_ctrl.sv
// rtl/pixel_readout_ctrl.sv - frame sequencer (erase/expose/convert/read) for the pixel array
// Define PIXEL_GRAY_RAMP_EN to drive ramp_count in Gray code instead of binary.
module pixel_readout_ctrl #(
  parameter int ROWS     = 2,
  parameter int COLS     = 8,
  parameter int ADC_BITS = 8,
  parameter int DATA_W   = 32,
  parameter int TIME_W   = 16,
  parameter int PPW      = DATA_W / ADC_BITS,
  parameter int GROUPS   = COLS / PPW,
  parameter int GRP_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                cont_mode,
  input  logic [TIME_W-1:0]   erase_time,
  input  logic [TIME_W-1:0]   expose_time,
  output logic                erase,
  output logic                expose,
  output logic                convert,
  output logic [ADC_BITS-1:0] ramp_count,
  output logic [ROWS-1:0]     row_sel,
  output logic [GRP_W-1:0]    col_grp,
  input  logic [DATA_W-1:0]   pix_data,
  output logic [DATA_W-1:0]   databus,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                frame_done
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ,
    S_DRAIN
  } state_t;

  state_t              state, state_nxt;
  logic [TIME_W-1:0]   timer;
  logic [TIME_W-1:0]   erase_len;
  logic [TIME_W-1:0]   expose_len;
  logic                cont_lat;
  logic [ADC_BITS-1:0] ramp_bin;
  logic [ROW_W-1:0]    row_idx;
  logic [GRP_W-1:0]    grp_idx;
  logic                capture;
  logic                last_addr;
  logic                accept_last;
  logic                relatch;

  assign capture     = (state == S_READ) && (!out_valid || out_ready);
  assign last_addr   = (row_idx == ROW_W'(ROWS - 1)) && (grp_idx == GRP_W'(GROUPS - 1));
  assign accept_last = (state == S_DRAIN) && out_valid && out_ready;
  assign relatch     = ((state == S_IDLE) && start) || (accept_last && cont_lat);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_ERASE;
      S_ERASE:   if (timer == erase_len - TIME_W'(1)) state_nxt = S_EXPOSE;
      S_EXPOSE:  if (timer == expose_len - TIME_W'(1)) state_nxt = S_CONVERT;
      S_CONVERT: if (ramp_bin == {ADC_BITS{1'b1}}) state_nxt = S_READ;
      S_READ:    if (capture && last_addr) state_nxt = S_DRAIN;
      S_DRAIN:   if (accept_last) state_nxt = cont_lat ? S_ERASE : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      erase_len  <= '0;
      expose_len <= '0;
      cont_lat   <= 1'b0;
      ramp_bin   <= '0;
      row_idx    <= '0;
      grp_idx    <= '0;
      databus    <= '0;
      out_valid  <= 1'b0;
    end else begin
      state <= state_nxt;

      // One shared duration timer, restarted on every state change.
      if ((state == S_ERASE || state == S_EXPOSE) && state_nxt == state)
        timer <= timer + TIME_W'(1);
      else
        timer <= '0;

      if (relatch) begin
        erase_len  <= (erase_time == '0) ? TIME_W'(1) : erase_time;
        expose_len <= (expose_time == '0) ? TIME_W'(1) : expose_time;
      end
      if (state == S_IDLE && start)
        cont_lat <= cont_mode;

      // The final increment wraps the ramp back to 0 as CONVERT ends.
      if (state == S_CONVERT)
        ramp_bin <= ramp_bin + ADC_BITS'(1);
      else
        ramp_bin <= '0;

      if (capture) begin
        databus   <= pix_data;
        out_valid <= 1'b1;
        if (grp_idx == GRP_W'(GROUPS - 1)) begin
          grp_idx <= '0;
          row_idx <= last_addr ? '0 : row_idx + ROW_W'(1);
        end else begin
          grp_idx <= grp_idx + GRP_W'(1);
        end
      end else if (accept_last) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    row_sel = '0;
    if (state == S_READ)
      row_sel[row_idx] = 1'b1;
  end

`ifdef PIXEL_GRAY_RAMP_EN
  assign ramp_count = ramp_bin ^ (ramp_bin >> 1);
`else
  assign ramp_count = ramp_bin;
`endif

  assign erase      = (state == S_ERASE);
  assign expose     = (state == S_EXPOSE);
  assign convert    = (state == S_CONVERT);
  assign col_grp    = grp_idx;
  assign busy       = (state != S_IDLE);
  assign frame_done = accept_last;

endmodule
